// File: rtl/rca_nibble_seq.sv
// Digit-serial adder: drives an external 4-bit ripple-carry adder one nibble per cycle
// and assembles the W-bit sum plus final carry behind a valid/ready handshake.
`timescale 1ns/1ps
module rca_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 cin,
  output logic [3:0]           fa_a,
  output logic [3:0]           fa_b,
  output logic                 fa_c,
  input  logic [3:0]           fa_sum,
  input  logic                 fa_carry,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          carry;
  logic [IW+1:0] base;

  assign base = {idx, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= op_a;
            b_q   <= op_b;
            carry <= cin;
            idx   <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          result[base +: 4] <= fa_sum;
          carry             <= fa_carry;
          idx               <= idx + 1'b1;
          // The final digit's carry becomes the overall carry out.
          if (idx == LAST) begin
            cout  <= fa_carry;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Adder inputs are parked at zero whenever no digit is being summed.
  always_comb begin
    fa_a = 4'h0;
    fa_b = 4'h0;
    fa_c = 1'b0;
    if (state == ADD) begin
      fa_a = a_q[base +: 4];
      fa_b = b_q[base +: 4];
      fa_c = carry;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_rca_nibble_seq.sv
// Directed and random checks of rca_nibble_seq at NIBBLES=4 and NIBBLES=2,
// each instance paired with a behavioural 4-bit adder.
`timescale 1ns/1ps
module tb_rca_nibble_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        in_valid4, in_ready4, cin4, fa_c4, fa_carry4, out_valid4, out_ready4, cout4, busy4;
  logic [15:0] op_a4, op_b4, result4;
  logic [3:0]  fa_a4, fa_b4, fa_sum4;

  logic        in_valid2, in_ready2, cin2, fa_c2, fa_carry2, out_valid2, out_ready2, cout2, busy2;
  logic [7:0]  op_a2, op_b2, result2;
  logic [3:0]  fa_a2, fa_b2, fa_sum2;

  int checks = 0;
  int errors = 0;

  assign {fa_carry4, fa_sum4} = {1'b0, fa_a4} + {1'b0, fa_b4} + {4'b0, fa_c4};
  assign {fa_carry2, fa_sum2} = {1'b0, fa_a2} + {1'b0, fa_b2} + {4'b0, fa_c2};

  rca_nibble_seq #(.NIBBLES(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .op_a(op_a4), .op_b(op_b4), .cin(cin4),
    .fa_a(fa_a4), .fa_b(fa_b4), .fa_c(fa_c4), .fa_sum(fa_sum4), .fa_carry(fa_carry4),
    .out_valid(out_valid4), .out_ready(out_ready4), .result(result4), .cout(cout4), .busy(busy4)
  );

  rca_nibble_seq #(.NIBBLES(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .op_a(op_a2), .op_b(op_b2), .cin(cin2),
    .fa_a(fa_a2), .fa_b(fa_b2), .fa_c(fa_c2), .fa_sum(fa_sum2), .fa_carry(fa_carry2),
    .out_valid(out_valid2), .out_ready(out_ready2), .result(result2), .cout(cout2), .busy(busy2)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid4 = 1'b1; op_a4 = 16'hAAAA; op_b4 = 16'h5555; cin4 = 1'b1;
    in_valid2 = 1'b1; op_a2 = 8'hAA;    op_b2 = 8'h55;    cin2 = 1'b1;
    step;
    step;
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy4); end
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid4); end
    checks++; if ({cout4, result4} !== 17'h0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 00000", {cout4, result4}); end
    checks++; if ({fa_a4, fa_b4, fa_c4} !== 9'h0) begin errors++; $display("[TB] FAIL reset_fa: got %h expected 000", {fa_a4, fa_b4, fa_c4}); end
    checks++; if ({busy2, cout2, result2} !== 10'h0) begin errors++; $display("[TB] FAIL reset_n2: got %h expected 000", {busy2, cout2, result2}); end
    rst = 1'b0;
    in_valid4 = 1'b0;
    in_valid2 = 1'b0;
    step;
    checks++; if (busy4 !== 1'b0) begin errors++; $display("[TB] FAIL reset_no_accept: got busy %b expected 0", busy4); end
  endtask

  task automatic test_basic_add;
    op_a4 = 16'h1234; op_b4 = 16'h4321; cin4 = 1'b0; in_valid4 = 1'b1;
    step;
    in_valid4 = 1'b0;
    checks++; if ({busy4, in_ready4} !== 2'b10) begin errors++; $display("[TB] FAIL basic_busy: got %b expected 10", {busy4, in_ready4}); end
    checks++; if ({fa_a4, fa_b4, fa_c4} !== {4'h4, 4'h1, 1'b0}) begin errors++; $display("[TB] FAIL basic_digit0: got %h expected 082", {fa_a4, fa_b4, fa_c4}); end
    for (int i = 1; i <= 4; i++) begin
      step;
      checks++; if (out_valid4 !== (i == 4)) begin errors++; $display("[TB] FAIL basic_latency cycle %0d: got %b expected %b", i, out_valid4, (i == 4)); end
    end
    checks++; if (result4 !== 16'h5555) begin errors++; $display("[TB] FAIL basic_result: got %h expected 5555", result4); end
    checks++; if (cout4 !== 1'b0) begin errors++; $display("[TB] FAIL basic_cout: got %b expected 0", cout4); end
    in_valid4 = 1'b1; op_a4 = 16'h1111; out_ready4 = 1'b1;
    step;
    in_valid4 = 1'b0; out_ready4 = 1'b0;
    checks++; if ({out_valid4, busy4, in_ready4} !== 3'b001) begin errors++; $display("[TB] FAIL basic_exit_no_accept: got %b expected 001", {out_valid4, busy4, in_ready4}); end
  endtask

  task automatic test_carry_chain;
    op_a4 = 16'hFFFF; op_b4 = 16'h0000; cin4 = 1'b1; in_valid4 = 1'b1;
    step;
    in_valid4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({fa_a4, fa_c4} !== {4'hF, 1'b1}) begin errors++; $display("[TB] FAIL chain_fa_c digit %0d: got %h expected 1f", i, {fa_a4, fa_c4}); end
      step;
    end
    checks++; if ({out_valid4, fa_a4, fa_c4} !== 6'b100000) begin errors++; $display("[TB] FAIL chain_done_fa: got %b expected 100000", {out_valid4, fa_a4, fa_c4}); end
    checks++; if ({cout4, result4} !== 17'h10000) begin errors++; $display("[TB] FAIL chain_sum: got %h expected 10000", {cout4, result4}); end
    out_ready4 = 1'b1;
    step;
    out_ready4 = 1'b0;
  endtask

  task automatic test_hold;
    op_a4 = 16'h8000; op_b4 = 16'h8000; cin4 = 1'b0; in_valid4 = 1'b1;
    step;
    in_valid4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      op_a4 = 16'($urandom); op_b4 = 16'($urandom); cin4 = 1'($urandom_range(0, 1));
      step;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid4, in_ready4, cout4, result4} !== {1'b1, 1'b0, 1'b1, 16'h0000}) begin
        errors++; $display("[TB] FAIL hold cycle %0d: got v%b r%b c%b %h expected v1 r0 c1 0000", i, out_valid4, in_ready4, cout4, result4);
      end
      step;
    end
    out_ready4 = 1'b1;
    step;
    out_ready4 = 1'b0;
    checks++; if ({busy4, in_ready4} !== 2'b01) begin errors++; $display("[TB] FAIL hold_release: got %b expected 01", {busy4, in_ready4}); end
  endtask

  task automatic test_reset_abort;
    int lat;
    op_a4 = 16'h1234; op_b4 = 16'h4321; cin4 = 1'b0; in_valid4 = 1'b1;
    step;
    in_valid4 = 1'b0;
    step;
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    checks++; if ({busy4, out_valid4, cout4, result4} !== 19'h0) begin errors++; $display("[TB] FAIL abort_state: got %h expected 00000", {busy4, out_valid4, cout4, result4}); end
    for (int i = 0; i < 6; i++) begin
      step;
      checks++; if (out_valid4 !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_valid cycle %0d: got %b expected 0", i, out_valid4); end
    end
    op_a4 = 16'h0001; op_b4 = 16'h0001; cin4 = 1'b0; in_valid4 = 1'b1;
    step;
    in_valid4 = 1'b0;
    lat = 0;
    while (out_valid4 !== 1'b1 && lat < 20) begin
      step;
      lat++;
    end
    checks++; if (lat != 4) begin errors++; $display("[TB] FAIL abort_followup_latency: got %0d expected 4", lat); end
    checks++; if ({cout4, result4} !== 17'h00002) begin errors++; $display("[TB] FAIL abort_followup_sum: got %h expected 00002", {cout4, result4}); end
    out_ready4 = 1'b1;
    step;
    out_ready4 = 1'b0;
  endtask

  task automatic test_random_n4;
    logic [15:0] a, b;
    logic        c;
    logic [16:0] exp;
    int          lat, done_cnt;
    done_cnt = 0;
    for (int t = 0; t < 1000; t++) begin
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom_range(0, 1));
      op_a4 = a; op_b4 = b; cin4 = c; in_valid4 = 1'b1; out_ready4 = 1'b0;
      checks++; if (in_ready4 !== 1'b1) begin errors++; $display("[TB] FAIL rnd4_ready txn %0d: got %b expected 1", t, in_ready4); end
      step;
      exp = {1'b0, a} + {1'b0, b} + {16'h0, c};
      lat = 0;
      while (out_valid4 !== 1'b1 && lat < 20) begin
        op_a4 = 16'($urandom); op_b4 = 16'($urandom); cin4 = 1'($urandom_range(0, 1));
        in_valid4 = 1'($urandom_range(0, 1));
        step;
        lat++;
      end
      checks++; if (lat != 4) begin errors++; $display("[TB] FAIL rnd4_latency txn %0d: got %0d expected 4", t, lat); end
      checks++; if ({cout4, result4} !== exp) begin errors++; $display("[TB] FAIL rnd4_sum txn %0d: got %h expected %h", t, {cout4, result4}, exp); end
      repeat ($urandom_range(0, 2)) step;
      out_ready4 = 1'b1; in_valid4 = 1'($urandom_range(0, 1));
      step;
      out_ready4 = 1'b0; in_valid4 = 1'b0;
      checks++; if (busy4 !== 1'b0) begin errors++; $display("[TB] FAIL rnd4_handshake txn %0d: got busy %b expected 0", t, busy4); end
      if (busy4 === 1'b0 && lat == 4) done_cnt++;
    end
    checks++; if (done_cnt != 1000) begin errors++; $display("[TB] FAIL rnd4_transfers: got %0d expected 1000", done_cnt); end
  endtask

  task automatic test_random_n2;
    logic [7:0] a, b;
    logic       c;
    logic [8:0] exp;
    int         lat, done_cnt;
    done_cnt = 0;
    for (int t = 0; t < 1000; t++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom_range(0, 1));
      op_a2 = a; op_b2 = b; cin2 = c; in_valid2 = 1'b1; out_ready2 = 1'b0;
      checks++; if (in_ready2 !== 1'b1) begin errors++; $display("[TB] FAIL rnd2_ready txn %0d: got %b expected 1", t, in_ready2); end
      step;
      exp = {1'b0, a} + {1'b0, b} + {8'h0, c};
      lat = 0;
      while (out_valid2 !== 1'b1 && lat < 20) begin
        op_a2 = 8'($urandom); op_b2 = 8'($urandom); cin2 = 1'($urandom_range(0, 1));
        in_valid2 = 1'($urandom_range(0, 1));
        step;
        lat++;
      end
      checks++; if (lat != 2) begin errors++; $display("[TB] FAIL rnd2_latency txn %0d: got %0d expected 2", t, lat); end
      checks++; if ({cout2, result2} !== exp) begin errors++; $display("[TB] FAIL rnd2_sum txn %0d: got %h expected %h", t, {cout2, result2}, exp); end
      repeat ($urandom_range(0, 2)) step;
      out_ready2 = 1'b1; in_valid2 = 1'($urandom_range(0, 1));
      step;
      out_ready2 = 1'b0; in_valid2 = 1'b0;
      checks++; if (busy2 !== 1'b0) begin errors++; $display("[TB] FAIL rnd2_handshake txn %0d: got busy %b expected 0", t, busy2); end
      if (busy2 === 1'b0 && lat == 2) done_cnt++;
    end
    checks++; if (done_cnt != 1000) begin errors++; $display("[TB] FAIL rnd2_transfers: got %0d expected 1000", done_cnt); end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    in_valid4 = 1'b0; op_a4 = 16'h0; op_b4 = 16'h0; cin4 = 1'b0; out_ready4 = 1'b0;
    in_valid2 = 1'b0; op_a2 = 8'h0;  op_b2 = 8'h0;  cin2 = 1'b0; out_ready2 = 1'b0;
    test_reset;
    test_basic_add;
    test_carry_chain;
    test_hold;
    test_reset_abort;
    test_random_n4;
    test_random_n2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
